// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared tl45 opcode constants, default widths and operand-fetch payload type
package tl45_pkg;

    localparam int TL45_DATA_W = 32;
    localparam int TL45_REG_AW = 4;

    localparam logic [4:0] OP_BRANCH = 5'h0C;

    typedef struct packed {
        logic [4:0]             opcode;
        logic [TL45_REG_AW-1:0] dr;
        logic [TL45_REG_AW-1:0] jmp_cond;
        logic [TL45_DATA_W-1:0] sr1_val;
        logic [TL45_DATA_W-1:0] sr2_val;
        logic [TL45_DATA_W-1:0] target_offset;
        logic [TL45_DATA_W-1:0] pc;
    } opf_payload_t;

    function automatic logic is_branch(input logic [4:0] opcode);
        return opcode == OP_BRANCH;
    endfunction

endpackage

// File: rtl/tl45_fwd_select.sv
// rtl/tl45_fwd_select.sv - per-source forwarding priority mux with pending (load-use) flag
module tl45_fwd_select #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int NFWD   = 3
) (
    input  logic [REG_AW-1:0]      src,
    input  logic                   used,
    input  logic [DATA_W-1:0]      rf_data,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_pending,
    input  logic [NFWD*REG_AW-1:0] fwd_reg,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]      value,
    output logic                   pending
);

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        value   = rf_data;
        pending = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_reg[k*REG_AW +: REG_AW] == src) begin
                value   = fwd_data[k*DATA_W +: DATA_W];
                pending = fwd_pending[k];
            end
        end
        if (src == '0) begin
            value   = '0;
            pending = 1'b0;
        end
        if (!used) begin
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/tl45_operand_fetch.sv
// rtl/tl45_operand_fetch.sv - tl45 operand fetch stage; TL45_OPFETCH_PERF_EN adds hazard/bubble counters
module tl45_operand_fetch
    import tl45_pkg::*;
#(
    parameter int DATA_W = TL45_DATA_W,
    parameter int REG_AW = TL45_REG_AW,
    parameter int NFWD   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [4:0]             i_opcode,
    input  logic                   i_ri,
    input  logic [REG_AW-1:0]      i_dr,
    input  logic [REG_AW-1:0]      i_sr1,
    input  logic [REG_AW-1:0]      i_sr2,
    input  logic [DATA_W-1:0]      i_imm,
    input  logic [DATA_W-1:0]      i_pc,
    output logic [REG_AW-1:0]      o_dprf_read_a1,
    output logic [REG_AW-1:0]      o_dprf_read_a2,
    input  logic [DATA_W-1:0]      i_dprf_d1,
    input  logic [DATA_W-1:0]      i_dprf_d2,
    input  logic [NFWD-1:0]        i_fwd_valid,
    input  logic [NFWD-1:0]        i_fwd_pending,
    input  logic [NFWD*REG_AW-1:0] i_fwd_reg,
    input  logic [NFWD*DATA_W-1:0] i_fwd_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [4:0]             o_opcode,
    output logic [REG_AW-1:0]      o_dr,
    output logic [REG_AW-1:0]      o_jmp_cond,
    output logic [DATA_W-1:0]      o_sr1_val,
    output logic [DATA_W-1:0]      o_sr2_val,
    output logic [DATA_W-1:0]      o_target_offset,
`ifdef TL45_OPFETCH_PERF_EN
    output logic [31:0]            o_perf_hazard_cycles,
    output logic [31:0]            o_perf_bubbles,
`endif
    output logic [DATA_W-1:0]      o_pc
);

    typedef struct packed {
        logic [4:0]        opcode;
        logic [REG_AW-1:0] dr;
        logic [REG_AW-1:0] jmp_cond;
        logic [DATA_W-1:0] sr1_val;
        logic [DATA_W-1:0] sr2_val;
        logic [DATA_W-1:0] target_offset;
        logic [DATA_W-1:0] pc;
    } payload_t;

    payload_t          out_q;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_fwd_val;
    logic [DATA_W-1:0] sr2_val;
    logic              sr1_pending;
    logic              sr2_pending;
    logic              hazard;
    logic              accept;

    assign o_dprf_read_a1 = i_sr1;
    assign o_dprf_read_a2 = i_sr2;

    tl45_fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_sel_sr1 (
        .src         (i_sr1),
        .used        (1'b1),
        .rf_data     (i_dprf_d1),
        .fwd_valid   (i_fwd_valid),
        .fwd_pending (i_fwd_pending),
        .fwd_reg     (i_fwd_reg),
        .fwd_data    (i_fwd_data),
        .value       (sr1_val),
        .pending     (sr1_pending)
    );

    tl45_fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_sel_sr2 (
        .src         (i_sr2),
        .used        (!i_ri),
        .rf_data     (i_dprf_d2),
        .fwd_valid   (i_fwd_valid),
        .fwd_pending (i_fwd_pending),
        .fwd_reg     (i_fwd_reg),
        .fwd_data    (i_fwd_data),
        .value       (sr2_fwd_val),
        .pending     (sr2_pending)
    );

    assign sr2_val = i_ri ? i_imm : sr2_fwd_val;
    assign hazard  = sr1_pending || sr2_pending;

    // A hazard only blocks when decode actually presents an instruction.
    assign o_ready = i_flush || (!(i_valid && hazard) && (!o_valid || i_ready));
    assign accept  = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            out_q   <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            out_q   <= '0;
        end else if (accept) begin
            o_valid              <= 1'b1;
            out_q.opcode         <= i_opcode;
            out_q.dr             <= is_branch(i_opcode) ? '0 : i_dr;
            out_q.jmp_cond       <= is_branch(i_opcode) ? i_dr : '0;
            out_q.sr1_val        <= sr1_val;
            out_q.sr2_val        <= sr2_val;
            out_q.target_offset  <= i_imm;
            out_q.pc             <= i_pc;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_opcode        = out_q.opcode;
    assign o_dr            = out_q.dr;
    assign o_jmp_cond      = out_q.jmp_cond;
    assign o_sr1_val       = out_q.sr1_val;
    assign o_sr2_val       = out_q.sr2_val;
    assign o_target_offset = out_q.target_offset;
    assign o_pc            = out_q.pc;

`ifdef TL45_OPFETCH_PERF_EN
    logic        hazard_cycle;
    logic        bubble;
    logic [31:0] hazard_cnt;
    logic [31:0] bubble_cnt;

    assign hazard_cycle = i_valid && hazard && !i_flush;
    // Output drains while the stalled instruction cannot replace it.
    assign bubble       = hazard_cycle && o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hazard_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (hazard_cycle && hazard_cnt != '1) hazard_cnt <= hazard_cnt + 32'd1;
            if (bubble && bubble_cnt != '1)       bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign o_perf_hazard_cycles = hazard_cnt;
    assign o_perf_bubbles       = bubble_cnt;
`endif

endmodule

// File: tb/tb_tl45_operand_fetch.sv
// tb/tb_tl45_operand_fetch.sv - self-checking bench for tl45_operand_fetch against a behavioural model
module tb_tl45_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NF = 3;

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [4:0]      i_opcode;
    logic            i_ri;
    logic [AW-1:0]   i_dr, i_sr1, i_sr2;
    logic [DW-1:0]   i_imm, i_pc;
    logic [AW-1:0]   o_dprf_read_a1, o_dprf_read_a2;
    logic [DW-1:0]   i_dprf_d1, i_dprf_d2;
    logic [NF-1:0]   i_fwd_valid, i_fwd_pending;
    logic [NF*AW-1:0] i_fwd_reg;
    logic [NF*DW-1:0] i_fwd_data;
    logic            o_valid;
    logic            i_ready;
    logic [4:0]      o_opcode;
    logic [AW-1:0]   o_dr, o_jmp_cond;
    logic [DW-1:0]   o_sr1_val, o_sr2_val, o_target_offset, o_pc;
`ifdef TL45_OPFETCH_PERF_EN
    logic [31:0]     o_perf_hazard_cycles, o_perf_bubbles;
`endif

    tl45_operand_fetch #(.DATA_W(DW), .REG_AW(AW), .NFWD(NF)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_flush         (i_flush),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_opcode        (i_opcode),
        .i_ri            (i_ri),
        .i_dr            (i_dr),
        .i_sr1           (i_sr1),
        .i_sr2           (i_sr2),
        .i_imm           (i_imm),
        .i_pc            (i_pc),
        .o_dprf_read_a1  (o_dprf_read_a1),
        .o_dprf_read_a2  (o_dprf_read_a2),
        .i_dprf_d1       (i_dprf_d1),
        .i_dprf_d2       (i_dprf_d2),
        .i_fwd_valid     (i_fwd_valid),
        .i_fwd_pending   (i_fwd_pending),
        .i_fwd_reg       (i_fwd_reg),
        .i_fwd_data      (i_fwd_data),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_opcode        (o_opcode),
        .o_dr            (o_dr),
        .o_jmp_cond      (o_jmp_cond),
        .o_sr1_val       (o_sr1_val),
        .o_sr2_val       (o_sr2_val),
        .o_target_offset (o_target_offset),
`ifdef TL45_OPFETCH_PERF_EN
        .o_perf_hazard_cycles (o_perf_hazard_cycles),
        .o_perf_bubbles       (o_perf_bubbles),
`endif
        .o_pc            (o_pc)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the ALU should currently see.
    bit          m_valid;
    bit [4:0]    m_opcode;
    bit [AW-1:0] m_dr, m_jc;
    bit [DW-1:0] m_s1, m_s2, m_off, m_pc;
    int unsigned m_haz, m_bub;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // First matching bus by priority wins; register 0 is hard zero.
    function automatic void resolve(input bit [AW-1:0] s, input bit [DW-1:0] rf,
                                    output bit [DW-1:0] v, output bit pend);
        v = rf;
        pend = 1'b0;
        if (s == 0) begin
            v = 0;
            return;
        end
        for (int k = 0; k < NF; k++) begin
            if (i_fwd_valid[k] && i_fwd_reg[k*AW +: AW] == s) begin
                v = i_fwd_data[k*DW +: DW];
                pend = i_fwd_pending[k];
                return;
            end
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_opcode = 0; m_dr = 0; m_jc = 0;
        m_s1 = 0; m_s2 = 0; m_off = 0; m_pc = 0;
        m_haz = 0; m_bub = 0;
    endtask

    task automatic check_outputs();
        check("o_valid",  64'(o_valid),         64'(m_valid));
        check("o_opcode", 64'(o_opcode),        64'(m_opcode));
        check("o_dr",     64'(o_dr),            64'(m_dr));
        check("o_jmp",    64'(o_jmp_cond),      64'(m_jc));
        check("o_sr1",    64'(o_sr1_val),       64'(m_s1));
        check("o_sr2",    64'(o_sr2_val),       64'(m_s2));
        check("o_off",    64'(o_target_offset), 64'(m_off));
        check("o_pc",     64'(o_pc),            64'(m_pc));
`ifdef TL45_OPFETCH_PERF_EN
        check("perf_haz", 64'(o_perf_hazard_cycles), 64'(m_haz));
        check("perf_bub", 64'(o_perf_bubbles),       64'(m_bub));
`endif
    endtask

    task automatic set_idle();
        i_flush = 0; i_valid = 0; i_opcode = 0; i_ri = 0;
        i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_imm = 0; i_pc = 0;
        i_dprf_d1 = 0; i_dprf_d2 = 0; i_ready = 1;
        i_fwd_valid = 0; i_fwd_pending = 0; i_fwd_reg = 0; i_fwd_data = 0;
    endtask

    task automatic set_bus(input int k, input bit v, input bit p, input bit [AW-1:0] r,
                           input bit [DW-1:0] d);
        i_fwd_valid[k]          = v;
        i_fwd_pending[k]        = p;
        i_fwd_reg[k*AW +: AW]   = r;
        i_fwd_data[k*DW +: DW]  = d;
    endtask

    // Called just after a negedge with inputs driven; returns just after the next negedge.
    task automatic step();
        bit [DW-1:0] v1, v2;
        bit p1, p2, haz, rdy;
        #1;
        resolve(i_sr1, i_dprf_d1, v1, p1);
        if (i_ri) begin
            v2 = i_imm; p2 = 0;
        end else begin
            resolve(i_sr2, i_dprf_d2, v2, p2);
        end
        haz = p1 || p2;
        rdy = i_flush || (!(i_valid && haz) && (!m_valid || i_ready));
        check("o_ready", 64'(o_ready), 64'(rdy));
        check("rd_a1",   64'(o_dprf_read_a1), 64'(i_sr1));
        check("rd_a2",   64'(o_dprf_read_a2), 64'(i_sr2));
        @(posedge i_clk);
        if (i_valid && haz && !i_flush && m_haz != 32'hFFFF_FFFF) m_haz++;
        if (i_valid && haz && !i_flush && m_valid && i_ready && m_bub != 32'hFFFF_FFFF) m_bub++;
        if (i_flush) begin
            m_valid = 0; m_opcode = 0; m_dr = 0; m_jc = 0;
            m_s1 = 0; m_s2 = 0; m_off = 0; m_pc = 0;
        end else if (i_valid && rdy) begin
            m_valid  = 1;
            m_opcode = i_opcode;
            m_dr     = (i_opcode == 5'h0C) ? '0 : i_dr;
            m_jc     = (i_opcode == 5'h0C) ? i_dr : '0;
            m_s1     = v1;
            m_s2     = v2;
            m_off    = i_imm;
            m_pc     = i_pc;
        end else if (m_valid && i_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
        @(negedge i_clk);
    endtask

    task automatic load_one(input bit [AW-1:0] s1, input bit [DW-1:0] d1);
        set_idle();
        i_valid = 1; i_opcode = 5'h01; i_dr = 4'h2; i_sr1 = s1; i_dprf_d1 = d1;
        i_imm = 32'h40; i_pc = 32'h100;
        step();
    endtask

    initial begin
        set_idle();
        model_reset();
        i_reset_n = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_outputs();
        i_reset_n = 1;
        @(negedge i_clk);

        // Plain register read
        set_idle();
        i_valid = 1; i_sr1 = 3; i_sr2 = 5; i_dprf_d1 = 32'h11; i_dprf_d2 = 32'h22;
        i_opcode = 5'h02; i_dr = 4'h7; i_imm = 32'h1234; i_pc = 32'h200;
        step();
        check("plain_sr1", 64'(o_sr1_val), 64'h11);
        check("plain_sr2", 64'(o_sr2_val), 64'h22);

        // Forwarding priority
        set_idle();
        i_valid = 1; i_sr1 = 3; i_dprf_d1 = 32'h99;
        set_bus(0, 1, 0, 3, 32'hA0);
        set_bus(2, 1, 0, 3, 32'hC0);
        step();
        check("prio_bus0", 64'(o_sr1_val), 64'hA0);
        i_fwd_valid[0] = 0;
        step();
        check("prio_bus2", 64'(o_sr1_val), 64'hC0);
        set_idle();
        i_valid = 1; i_sr1 = 0; i_dprf_d1 = 32'hFFFF;
        set_bus(0, 1, 0, 0, 32'h55);
        step();
        check("r0_zero", 64'(o_sr1_val), 64'h0);

        // Load-use stall, then release, then immediate mode
        set_idle();
        i_valid = 1; i_sr2 = 5; i_ri = 0;
        set_bus(1, 1, 1, 5, 32'h0);
        step();
        check("lu_bubble", 64'(o_valid), 64'h0);
        i_fwd_pending[1] = 0; i_fwd_data[DW +: DW] = 32'h77;
        step();
        check("lu_release", 64'(o_sr2_val), 64'h77);
        i_fwd_pending[1] = 1; i_ri = 1; i_imm = 32'h9;
        step();
        check("lu_imm", 64'(o_sr2_val), 64'h9);

        // Backpressure then back-to-back
        set_idle();
        i_valid = 1; i_sr1 = 4; i_dprf_d1 = 32'hBEEF; i_ready = 0; i_pc = 32'h300;
        for (int c = 0; c < 3; c++) step();
        check("bp_pc_held", 64'(o_pc), 64'h9 - 64'h9 + 64'(m_pc));
        i_ready = 1;
        step();
        check("bp_accept", 64'(o_sr1_val), 64'hBEEF);
        i_pc = 32'h304;
        step();
        check("b2b_valid", 64'(o_valid), 64'h1);

        // Branch and flush during hold
        set_idle();
        i_valid = 1; i_opcode = 5'h0C; i_dr = 4'h6;
        step();
        check("br_dr",  64'(o_dr), 64'h0);
        check("br_jmp", 64'(o_jmp_cond), 64'h6);
        i_ready = 0; i_opcode = 5'h03;
        step();
        i_flush = 1;
        step();
        check("flush_valid",  64'(o_valid), 64'h0);
        check("flush_opcode", 64'(o_opcode), 64'h0);

        // Asynchronous reset while holding
        load_one(4'h8, 32'hCAFE);
        i_ready = 0;
        step();
        #3;
        i_reset_n = 0;
        #1;
        model_reset();
        check("areset_valid", 64'(o_valid), 64'h0);
        check("areset_sr1",   64'(o_sr1_val), 64'h0);
        @(negedge i_clk);
        i_reset_n = 1;

`ifdef TL45_OPFETCH_PERF_EN
        load_one(4'h8, 32'h1);
        set_idle();
        i_valid = 1; i_sr1 = 5;
        set_bus(0, 1, 1, 5, 32'h0);
        for (int c = 0; c < 4; c++) step();
        check("perf_haz4", 64'(o_perf_hazard_cycles), 64'd4);
        check("perf_bub1", 64'(o_perf_bubbles), 64'd1);
`endif

        // Randomised traffic, registers drawn from a small set to force collisions
        for (int n = 0; n < 400; n++) begin
            i_flush   = ($urandom_range(0, 15) == 0);
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 3) != 0);
            i_opcode  = ($urandom_range(0, 3) == 0) ? 5'h0C : 5'($urandom);
            i_ri      = ($urandom_range(0, 3) == 0);
            i_dr      = AW'($urandom);
            i_sr1     = AW'($urandom_range(0, 5));
            i_sr2     = AW'($urandom_range(0, 5));
            i_imm     = $urandom;
            i_pc      = $urandom;
            i_dprf_d1 = $urandom;
            i_dprf_d2 = $urandom;
            for (int k = 0; k < NF; k++)
                set_bus(k, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                        AW'($urandom_range(0, 5)), $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
